// File: rtl/rd_result_collector_if.sv
// Issue / functional-unit / writeback bundle for rd_result_collector.
// The slave modport is the collector's view; master is the surrounding pipeline.
interface rd_result_collector_if #(
  parameter int unsigned N        = 16,
  parameter int unsigned SEL_LINE = 4,
  parameter int unsigned NUM_FU   = 7,
  parameter int unsigned ADDR_W   = 4
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [SEL_LINE-1:0]   issue_opcode;
  logic [ADDR_W-1:0]     issue_rd_addr;
  logic [NUM_FU*N-1:0]   fu_result;
  logic [NUM_FU-1:0]     fu_done;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [N-1:0]          wb_data;
  logic [ADDR_W-1:0]     wb_rd_addr;
  logic [SEL_LINE-1:0]   wb_opcode;
  logic                  wb_zero;
  logic                  wb_neg;
  logic                  wb_illegal;
  logic                  fu_overflow;

  modport slave (
    input  issue_valid, issue_opcode, issue_rd_addr, fu_result, fu_done, wb_ready,
    output issue_ready, wb_valid, wb_data, wb_rd_addr, wb_opcode,
           wb_zero, wb_neg, wb_illegal, fu_overflow
  );

  modport master (
    output issue_valid, issue_opcode, issue_rd_addr, fu_result, fu_done, wb_ready,
    input  issue_ready, wb_valid, wb_data, wb_rd_addr, wb_opcode,
           wb_zero, wb_neg, wb_illegal, fu_overflow
  );
endinterface

// File: rtl/rd_result_collector.sv
// In-order retire of issued ALU ops: results from variable-latency units are held
// per unit until their op reaches the queue head, then loaded into a registered writeback slot.
module rd_result_collector #(
  parameter int unsigned N        = 16,
  parameter int unsigned SEL_LINE = 4,
  parameter int unsigned NUM_FU   = 7,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rd_result_collector_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SEL_LINE-1:0] q_op_q [DEPTH];
  logic [SEL_LINE-1:0] q_op_d [DEPTH];
  logic [ADDR_W-1:0]   q_rd_q [DEPTH];
  logic [ADDR_W-1:0]   q_rd_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                issue_ready_q, issue_ready_d;

  logic [N-1:0]        hold_q [NUM_FU];
  logic [N-1:0]        hold_d [NUM_FU];
  logic [NUM_FU-1:0]   hold_v_q, hold_v_d;
  logic                overflow_q, overflow_d;

  logic                wb_valid_q, wb_valid_d;
  logic [N-1:0]        wb_data_q, wb_data_d;
  logic [ADDR_W-1:0]   wb_rd_q, wb_rd_d;
  logic [SEL_LINE-1:0] wb_op_q, wb_op_d;
  logic                wb_zero_q, wb_zero_d;
  logic                wb_neg_q, wb_neg_d;
  logic                wb_ill_q, wb_ill_d;

  logic [SEL_LINE-1:0] head_op_c;
  logic                head_illegal_c, head_hit_c, push_c, retire_c;
  logic [N-1:0]        head_data_c, retire_data_c;

  // Next-state: queue, hold registers and writeback slot
  always_comb begin
    q_op_d        = q_op_q;
    q_rd_d        = q_rd_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    hold_d        = hold_q;
    hold_v_d      = hold_v_q;
    overflow_d    = overflow_q;
    wb_valid_d    = wb_valid_q;
    wb_data_d     = wb_data_q;
    wb_rd_d       = wb_rd_q;
    wb_op_d       = wb_op_q;
    wb_zero_d     = wb_zero_q;
    wb_neg_d      = wb_neg_q;
    wb_ill_d      = wb_ill_q;
    head_hit_c    = 1'b0;
    head_data_c   = '0;

    head_op_c      = q_op_q[rd_ptr_q];
    head_illegal_c = (32'(head_op_c) >= NUM_FU);
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (head_op_c == SEL_LINE'(i)) begin
        head_hit_c  = hold_v_q[i];
        head_data_c = hold_q[i];
      end
    end

    push_c   = bus.issue_valid && issue_ready_q;
    retire_c = (count_q != '0) && (!wb_valid_q || bus.wb_ready) &&
               (head_illegal_c || head_hit_c);
    retire_data_c = head_illegal_c ? '0 : head_data_c;

    if (push_c) begin
      q_op_d[wr_ptr_q] = bus.issue_opcode;
      q_rd_d[wr_ptr_q] = bus.issue_rd_addr;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (retire_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d       = count_q + CNT_W'(push_c) - CNT_W'(retire_c);
    issue_ready_d = (count_d < CNT_W'(DEPTH));

    // A capture in the same cycle as consumption keeps the hold valid
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (bus.fu_done[i]) begin
        hold_d[i]   = bus.fu_result[i*N +: N];
        hold_v_d[i] = 1'b1;
        if (hold_v_q[i] && !(retire_c && !head_illegal_c && head_op_c == SEL_LINE'(i)))
          overflow_d = 1'b1;
      end else if (retire_c && !head_illegal_c && head_op_c == SEL_LINE'(i)) begin
        hold_v_d[i] = 1'b0;
      end
    end

    if (retire_c) begin
      wb_valid_d = 1'b1;
      wb_data_d  = retire_data_c;
      wb_rd_d    = q_rd_q[rd_ptr_q];
      wb_op_d    = head_op_c;
      wb_ill_d   = head_illegal_c;
      wb_zero_d  = (retire_data_c == '0);
      wb_neg_d   = retire_data_c[N-1];
    end else if (wb_valid_q && bus.wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_op_q[i] <= '0;
        q_rd_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NUM_FU; i++) hold_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      issue_ready_q <= 1'b1;
      hold_v_q      <= '0;
      overflow_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_op_q       <= '0;
      wb_zero_q     <= 1'b0;
      wb_neg_q      <= 1'b0;
      wb_ill_q      <= 1'b0;
    end else begin
      q_op_q        <= q_op_d;
      q_rd_q        <= q_rd_d;
      hold_q        <= hold_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      issue_ready_q <= issue_ready_d;
      hold_v_q      <= hold_v_d;
      overflow_q    <= overflow_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      wb_op_q       <= wb_op_d;
      wb_zero_q     <= wb_zero_d;
      wb_neg_q      <= wb_neg_d;
      wb_ill_q      <= wb_ill_d;
    end
  end

  assign bus.issue_ready = issue_ready_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd_addr  = wb_rd_q;
  assign bus.wb_opcode   = wb_op_q;
  assign bus.wb_zero     = wb_zero_q;
  assign bus.wb_neg      = wb_neg_q;
  assign bus.wb_illegal  = wb_ill_q;
  assign bus.fu_overflow = overflow_q;

endmodule

// File: tb/tb_rd_result_collector.sv
// Directed bench for rd_result_collector: latency, ordering, backpressure, illegal ops,
// overflow and asynchronous reset, with hand-computed expectations.
module tb_rd_result_collector;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rd_result_collector_if #(.N(16), .SEL_LINE(4), .NUM_FU(7), .ADDR_W(4)) bus ();

  rd_result_collector #(.N(16), .SEL_LINE(4), .NUM_FU(7), .DEPTH(4), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd);
    bus.issue_valid   = 1'b1;
    bus.issue_opcode  = op;
    bus.issue_rd_addr = rd;
    step();
    bus.issue_valid   = 1'b0;
  endtask

  task automatic done(input int unsigned u, input logic [15:0] val);
    bus.fu_result[u*16 +: 16] = val;
    bus.fu_done[u]            = 1'b1;
    step();
    bus.fu_done               = '0;
  endtask

  task automatic check_wb(input string tag, input logic [15:0] data, input logic [3:0] rd,
                          input logic [3:0] op, input logic ill, input logic z, input logic n);
    check({tag, "_valid"},   32'(bus.wb_valid),   32'd1);
    check({tag, "_data"},    32'(bus.wb_data),    32'(data));
    check({tag, "_rd"},      32'(bus.wb_rd_addr), 32'(rd));
    check({tag, "_opcode"},  32'(bus.wb_opcode),  32'(op));
    check({tag, "_illegal"}, 32'(bus.wb_illegal), 32'(ill));
    check({tag, "_zero"},    32'(bus.wb_zero),    32'(z));
    check({tag, "_neg"},     32'(bus.wb_neg),     32'(n));
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    bus.issue_valid   = 1'b0;
    bus.issue_opcode  = '0;
    bus.issue_rd_addr = '0;
    bus.fu_result     = '0;
    bus.fu_done       = '0;
    bus.wb_ready      = 1'b0;
    step();
    step();
    check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    check("rst_wb_valid",    32'(bus.wb_valid),    32'd0);
    check("rst_wb_data",     32'(bus.wb_data),     32'd0);
    check("rst_wb_rd",       32'(bus.wb_rd_addr),  32'd0);
    check("rst_wb_opcode",   32'(bus.wb_opcode),   32'd0);
    check("rst_wb_zero",     32'(bus.wb_zero),     32'd0);
    check("rst_wb_neg",      32'(bus.wb_neg),      32'd0);
    check("rst_wb_illegal",  32'(bus.wb_illegal),  32'd0);
    check("rst_overflow",    32'(bus.fu_overflow), 32'd0);
    rst_n = 1'b1;
    step();

    // Single op: done at t, wb_valid at t+2
    bus.wb_ready = 1'b1;
    issue(4'd0, 4'd5);
    done(0, 16'h0007);
    check("single_lat_t1", 32'(bus.wb_valid), 32'd0);
    step();
    check_wb("single", 16'h0007, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("single_drain", 32'(bus.wb_valid), 32'd0);

    // Out-of-order completion: add finishes first, div retires first
    issue(4'd3, 4'd1);
    issue(4'd0, 4'd2);
    done(0, 16'h0003);
    check("ooo_wait", 32'(bus.wb_valid), 32'd0);
    step();
    step();
    done(3, 16'h8000);
    check("ooo_lat_t1", 32'(bus.wb_valid), 32'd0);
    step();
    check_wb("ooo_div", 16'h8000, 4'd1, 4'd3, 1'b0, 1'b0, 1'b1);
    step();
    check_wb("ooo_add", 16'h0003, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("ooo_drain", 32'(bus.wb_valid), 32'd0);

    // Backpressure and full queue
    bus.wb_ready = 1'b0;
    issue(4'd1, 4'd10);
    issue(4'd2, 4'd11);
    issue(4'd5, 4'd12);
    check("full_ready_pre", 32'(bus.issue_ready), 32'd1);
    issue(4'd6, 4'd13);
    check("full_ready", 32'(bus.issue_ready), 32'd0);
    issue(4'd0, 4'd15);
    check("full_reject", 32'(bus.issue_ready), 32'd0);
    bus.fu_result[1*16 +: 16] = 16'h0011;
    bus.fu_result[2*16 +: 16] = 16'h0022;
    bus.fu_result[5*16 +: 16] = 16'h0055;
    bus.fu_result[6*16 +: 16] = 16'h0066;
    bus.fu_done = 7'b1100110;
    step();
    bus.fu_done = '0;
    step();
    check_wb("bp_first", 16'h0011, 4'd10, 4'd1, 1'b0, 1'b0, 1'b0);
    check("bp_ready_again", 32'(bus.issue_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_data",  32'(bus.wb_data),    32'h0011);
      check("bp_hold_valid", 32'(bus.wb_valid),   32'd1);
      check("bp_hold_rd",    32'(bus.wb_rd_addr), 32'd10);
    end
    bus.wb_ready = 1'b1;
    step();
    check_wb("bp_second", 16'h0022, 4'd11, 4'd2, 1'b0, 1'b0, 1'b0);
    step();
    check_wb("bp_third",  16'h0055, 4'd12, 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    check_wb("bp_fourth", 16'h0066, 4'd13, 4'd6, 1'b0, 1'b0, 1'b0);
    step();
    check("bp_no_fifth", 32'(bus.wb_valid), 32'd0);

    // Illegal opcode retires with zero, then a legal zero result
    issue(4'hF, 4'd9);
    check("ill_lat", 32'(bus.wb_valid), 32'd0);
    step();
    check_wb("ill", 16'h0000, 4'd9, 4'hF, 1'b1, 1'b1, 1'b0);
    step();
    check("ill_drain", 32'(bus.wb_valid), 32'd0);
    issue(4'd1, 4'd3);
    done(1, 16'h0000);
    step();
    check_wb("zero", 16'h0000, 4'd3, 4'd1, 1'b0, 1'b1, 1'b0);
    step();

    // Overflow: two captures into unit 2 with nothing consuming it
    done(2, 16'h0001);
    check("ovf_first", 32'(bus.fu_overflow), 32'd0);
    done(2, 16'h0002);
    check("ovf_set", 32'(bus.fu_overflow), 32'd1);
    step();
    step();
    check("ovf_sticky", 32'(bus.fu_overflow), 32'd1);

    // Reset mid-operation: one op in writeback, three pending
    bus.wb_ready = 1'b0;
    issue(4'd0, 4'd1);
    issue(4'd1, 4'd2);
    issue(4'd2, 4'd3);
    issue(4'd6, 4'd4);
    done(0, 16'h0005);
    step();
    check("mid_wb_valid", 32'(bus.wb_valid),    32'd1);
    check("mid_data",     32'(bus.wb_data),     32'h0005);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    32'(bus.wb_valid),    32'd0);
    check("mid_rst_ready",    32'(bus.issue_ready), 32'd1);
    check("mid_rst_overflow", 32'(bus.fu_overflow), 32'd0);
    check("mid_rst_data",     32'(bus.wb_data),     32'd0);
    step();
    rst_n = 1'b1;
    step();
    bus.wb_ready = 1'b1;
    issue(4'd2, 4'd7);
    step();
    check("post_rst_no_stale", 32'(bus.wb_valid), 32'd0);
    done(2, 16'h1234);
    check("post_rst_lat", 32'(bus.wb_valid), 32'd0);
    step();
    check_wb("post_rst", 16'h1234, 4'd7, 4'd2, 1'b0, 1'b0, 1'b0);
    step();
    check("post_rst_drain", 32'(bus.wb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
